// File: rtl/rle_stream_writer.sv
// Expands run-length tokens into MSB-first bits packed into masked memory word writes,
// starting from an arbitrary word address and bit index.
module rle_stream_writer #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 16,
   parameter int RUN_W  = 7,
   parameter int IDX_W  = $clog2(WORD_W)
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [IDX_W-1:0]  start_bit,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic              tok_bit,
   input  logic [RUN_W-1:0]  tok_len,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              err_wrap,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [IDX_W-1:0]  cur_bit,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [WORD_W-1:0] mem_wmask
);

   localparam int CNT_W = (RUN_W > IDX_W + 1) ? RUN_W : IDX_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_FILL, S_FLUSH} state_t;

   state_t            r_state;
   logic [WORD_W-1:0] r_accum;
   logic [WORD_W-1:0] r_mask;
   logic [RUN_W-1:0]  r_rem;
   logic              r_val;
   logic              r_done;
   logic              r_err_wrap;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [IDX_W-1:0]  r_cur_bit;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [WORD_W-1:0] r_mem_wdata;
   logic [WORD_W-1:0] r_mem_wmask;

   logic [CNT_W-1:0]  w_room;
   logic [CNT_W-1:0]  w_rem_ext;
   logic [CNT_W-1:0]  w_n;
   logic              w_word_done;
   logic [RUN_W-1:0]  w_rem_next;
   logic [WORD_W-1:0] w_chunk;
   logic [WORD_W-1:0] w_accum_next;
   logic [WORD_W-1:0] w_mask_next;

   // One chunk per FILL cycle: as many bits as fit between cur_bit and bit 0.
   always_comb begin
      w_room      = CNT_W'(r_cur_bit) + CNT_W'(1);
      w_rem_ext   = CNT_W'(r_rem);
      w_n         = (w_rem_ext < w_room) ? w_rem_ext : w_room;
      w_word_done = (w_n == w_room);
      w_rem_next  = r_rem - RUN_W'(w_n);
      w_chunk     = '0;
      for (int i = 0; i < WORD_W; i++) begin
         if ((i <= int'(r_cur_bit)) && ((i + int'(w_n)) > int'(r_cur_bit)))
            w_chunk[i] = 1'b1;
      end
      w_accum_next = r_accum | (r_val ? w_chunk : '0);
      w_mask_next  = r_mask | w_chunk;
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_accum     <= '0;
         r_mask      <= '0;
         r_rem       <= '0;
         r_val       <= 1'b0;
         r_done      <= 1'b0;
         r_err_wrap  <= 1'b0;
         r_cur_addr  <= '0;
         r_cur_bit   <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur_addr <= start_addr;
                  r_cur_bit  <= start_bit;
                  r_accum    <= '0;
                  r_mask     <= '0;
                  r_err_wrap <= 1'b0;
                  r_state    <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (flush) begin
                  r_state <= S_FLUSH;
               end else if (tok_valid) begin
                  r_rem <= tok_len;
                  r_val <= tok_bit;
                  if (tok_len != '0)
                     r_state <= S_FILL;
               end
            end
            S_FILL: begin
               r_rem <= w_rem_next;
               if (w_word_done) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_cur_addr;
                  r_mem_wdata <= w_accum_next;
                  r_mem_wmask <= w_mask_next;
                  r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                  if (&r_cur_addr)
                     r_err_wrap <= 1'b1;
                  r_cur_bit   <= IDX_W'(WORD_W - 1);
                  r_accum     <= '0;
                  r_mask      <= '0;
               end else begin
                  r_accum   <= w_accum_next;
                  r_mask    <= w_mask_next;
                  r_cur_bit <= r_cur_bit - IDX_W'(w_n);
               end
               if (w_rem_next == '0)
                  r_state <= S_ACCEPT;
            end
            S_FLUSH: begin
               // Pointer is left alone so a later session can finish this word.
               if (|r_mask) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_cur_addr;
                  r_mem_wdata <= r_accum;
                  r_mem_wmask <= r_mask;
               end
               r_done  <= 1'b1;
               r_accum <= '0;
               r_mask  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tok_ready = (r_state == S_ACCEPT) && !flush;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign err_wrap  = r_err_wrap;
   assign cur_addr  = r_cur_addr;
   assign cur_bit   = r_cur_bit;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;

endmodule
